csr_timer_unit: RTL and testbench
=================================

Name: csr_timer_unit

Overview:
Timer and interrupt-source block that sits directly upstream of the CSR file. It owns the TID, TCFG, TVAL and TICLR registers and the 64-bit stable counter. It produces the timer interrupt bit for ESTAT.IS[11] and the synchronized hardware and IPI interrupt lines for ESTAT.IS[9:2] and IS[12]. It shares the CSR read/write bus and returns read data plus a hit flag, which the CSR file merges into its own read mux.

Parameters:
CORE_ID, 0, reset value of TID and value driven on rdcnt ID path
HW_INT_NUM, 8, number of external hardware interrupt lines
SYNC_STAGES, 2, flop depth of interrupt input synchronizer (>=2)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
csr_re  in  1  read enable
csr_num  in  CSR_NUM_WIDTH  CSR index (TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44)
csr_we  in  1  write enable
csr_wmask  in  32  write bit mask
csr_wvalue  in  32  write data
csr_rvalue  out  32  read data; 0 when no hit
csr_hit  out  1  csr_re asserted and csr_num is one of the four owned CSRs
hw_int_in  in  HW_INT_NUM  asynchronous external interrupt lines
ipi_int_in  in  1  asynchronous inter-processor interrupt
timer_int  out  1  latched timer interrupt, feeds ESTAT.IS[11]
hw_int_sync  out  HW_INT_NUM  synchronized hw_int_in, feeds ESTAT.IS[9:2]
ipi_int_sync  out  1  synchronized ipi_int_in, feeds ESTAT.IS[12]
stable_cnt  out  64  stable counter value for rdcntvl.w / rdcntvh.w
tid  out  32  current TID for rdcntid.w

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - tid=CORE_ID, tcfg=0, timer_cnt=32'hFFFF_FFFF, timer_int=0
  - stable_cnt=0; all synchronizer flops=0
- Masked write rule for every register field: new = wmask&wvalue | ~wmask&old. "Effective" values below are after this merge.
- TID: full 32-bit read/write.
- TCFG fields: En=[0], Periodic=[1], InitVal=[31:2]. Read returns {InitVal,Periodic,En}.
- TVAL: read-only and returns timer_cnt. Writes are ignored.
- TICLR: reads 0. A write with effective bit0=1 clears timer_int next cycle. All other bits are ignored.
- Timer counter, evaluated each cycle in priority order:
  1. TCFG write with effective En=1: timer_cnt <= {effective InitVal,2'b00}. This overrides any decrement in the same cycle.
  2. En=1 and timer_cnt==0:
     - timer_int <= 1
     - if Periodic=1: timer_cnt <= {InitVal,2'b00}
     - else: timer_cnt <= 32'hFFFF_FFFF, then holds there (one-shot stop)
  3. En=1 and timer_cnt!=32'hFFFF_FFFF: timer_cnt <= timer_cnt-1
  4. Otherwise: hold.
- Clearing En freezes timer_cnt at its current value. It does not clear timer_int.
- Periodic with InitVal=0 raises timer_int every cycle. This is legal.
- timer_int set vs TICLR clear in the same cycle: set wins, timer_int stays 1.
- First interrupt timing: after a TCFG write of InitVal=N with En=1 at edge k, timer_int rises at edge k+4N+1.
- stable_cnt increments by 1 every cycle. Wraps from 2^64-1 to 0. Not writable.
- Synchronizers: hw_int_sync and ipi_int_sync lag their inputs by SYNC_STAGES cycles. No edge detection; levels pass through.
- Reads are combinational, zero latency. csr_rvalue=0 when csr_hit=0.
- wb_ex and ertn have no effect on this block.

Decomposition:
- Shared constants header gains:
  - CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR indices
  - field ranges CSR_TCFG_EN, CSR_TCFG_PERIOD, CSR_TCFG_INITV, CSR_TICLR_CLR, CSR_TID_TID
  - ESTAT bit positions CSR_ESTAT_IS_TI=11, CSR_ESTAT_IS_IPI=12
- One sub-module, int_sync: parameterized width/depth flop chain with async active-low reset. Instantiated once for {ipi_int_in, hw_int_in}.

Test Plan:
1. Reset released -> tid=CORE_ID, TVAL read=FFFF_FFFF, timer_int=0. stable_cnt=0 first cycle, =5 five cycles later.
2. Write TCFG=0x0000_0011 (InitVal=4, En=1, one-shot):
   - TVAL reads 16, 15, ... on successive cycles
   - timer_int=1 at edge k+17
   - TVAL then reads FFFF_FFFF and holds
   - TICLR write 1 -> timer_int=0 next cycle and stays 0
3. Write TCFG=0x0000_0007 (InitVal=1, Periodic, En):
   - timer_int sets at k+5
   - counter reloads to 4
   - clearing via TICLR -> re-sets 5 cycles after the previous set
4. Periodic TCFG with InitVal=0 + TICLR write on the cycle cnt==0 -> timer_int remains 1 (set priority).
5. Mid-count TCFG write with wmask=0x1, wvalue=0 -> TVAL freezes. Rewrite En=1 -> reload to {InitVal,00}.
6. hw_int_in=8'hA5 asserted at edge k -> hw_int_sync=8'hA5 at k+SYNC_STAGES. Reset pulsed mid-count -> all outputs return to reset values immediately, before any clock edge.

Source files
------------

// File: rtl/csr_timer_unit_pkg.sv
// Shared CSR constants for the timer/interrupt-source block: CSR indices,
// field positions, ESTAT interrupt bit positions and the masked-write helper.
package csr_timer_unit_pkg;

  localparam int CSR_NUM_WIDTH = 14;

  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID   = 14'h0040;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG  = 14'h0041;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL  = 14'h0042;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR = 14'h0044;

  localparam int CSR_TCFG_EN         = 0;
  localparam int CSR_TCFG_PERIOD     = 1;
  localparam int CSR_TCFG_INITV_LSB  = 2;
  localparam int CSR_TCFG_INITV_MSB  = 31;
  localparam int CSR_TICLR_CLR       = 0;
  localparam int CSR_TID_TID_LSB     = 0;
  localparam int CSR_TID_TID_MSB     = 31;

  localparam int CSR_ESTAT_IS_TI  = 11;
  localparam int CSR_ESTAT_IS_IPI = 12;

  // Counter value meaning "expired one-shot, stopped"
  localparam logic [31:0] TIMER_IDLE = 32'hFFFF_FFFF;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_val);
  endfunction

  // Assembles ESTAT.IS[12:2] from this block's outputs for the CSR file
  function automatic logic [12:0] estat_is_pack(input logic       ti,
                                                input logic       ipi,
                                                input logic [7:0] hw);
    logic [12:0] is_v;
    is_v = 13'h0000;
    is_v[9:2] = hw;
    is_v[CSR_ESTAT_IS_TI] = ti;
    is_v[CSR_ESTAT_IS_IPI] = ipi;
    return is_v;
  endfunction

endpackage

// File: rtl/csr_timer_unit_int_sync.sv
// Multi-flop level synchronizer for asynchronous interrupt lines.
module csr_timer_unit_int_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] sync_r;

  // Shift chain; stage 0 samples the asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/csr_timer_unit.sv
// Timer / interrupt-source block: owns TID, TCFG, TVAL, TICLR and the 64-bit
// stable counter, and synchronizes the external and IPI interrupt lines.
module csr_timer_unit
  import csr_timer_unit_pkg::*;
#(
  parameter logic [31:0] CORE_ID     = 32'h0000_0000,
  parameter int          HW_INT_NUM  = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_re,
  input  logic [CSR_NUM_WIDTH-1:0] csr_num,
  input  logic                     csr_we,
  input  logic [31:0]              csr_wmask,
  input  logic [31:0]              csr_wvalue,
  output logic [31:0]              csr_rvalue,
  output logic                     csr_hit,
  input  logic [HW_INT_NUM-1:0]    hw_int_in,
  input  logic                     ipi_int_in,
  output logic                     timer_int,
  output logic [HW_INT_NUM-1:0]    hw_int_sync,
  output logic                     ipi_int_sync,
  output logic [63:0]              stable_cnt,
  output logic [31:0]              tid
);

  logic        wr_tid_s, wr_tcfg_s, wr_ticlr_s;
  logic [31:0] tid_eff_s, tcfg_eff_s, reload_s, cnt_nxt_s;
  logic        ti_set_s, ti_clr_s, hit_s;
  logic [31:0] rvalue_s;
  logic [31:0] tid_r, tcfg_r, timer_cnt_r;
  logic        timer_int_r;
  logic [63:0] stable_cnt_r;

  assign wr_tid_s   = csr_we & (csr_num == CSR_TID);
  assign wr_tcfg_s  = csr_we & (csr_num == CSR_TCFG);
  assign wr_ticlr_s = csr_we & (csr_num == CSR_TICLR);
  assign tid_eff_s  = csr_merge(tid_r, csr_wmask, csr_wvalue);
  assign tcfg_eff_s = csr_merge(tcfg_r, csr_wmask, csr_wvalue);
  assign reload_s   = {tcfg_r[CSR_TCFG_INITV_MSB:CSR_TCFG_INITV_LSB], 2'b00};
  // TICLR always reads 0, so the merged bit reduces to mask & value
  assign ti_clr_s   = wr_ticlr_s & csr_wmask[CSR_TICLR_CLR] & csr_wvalue[CSR_TICLR_CLR];

  // Timer counter next value and interrupt set, in rule priority order
  always_comb begin
    ti_set_s  = 1'b0;
    cnt_nxt_s = timer_cnt_r;
    if (wr_tcfg_s && tcfg_eff_s[CSR_TCFG_EN]) begin
      cnt_nxt_s = {tcfg_eff_s[CSR_TCFG_INITV_MSB:CSR_TCFG_INITV_LSB], 2'b00};
    end else if (tcfg_r[CSR_TCFG_EN] && (timer_cnt_r == 32'h0000_0000)) begin
      ti_set_s  = 1'b1;
      cnt_nxt_s = tcfg_r[CSR_TCFG_PERIOD] ? reload_s : TIMER_IDLE;
    end else if (tcfg_r[CSR_TCFG_EN] && (timer_cnt_r != TIMER_IDLE)) begin
      cnt_nxt_s = timer_cnt_r - 32'h0000_0001;
    end else begin
      cnt_nxt_s = timer_cnt_r;
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tid_r        <= CORE_ID;
      tcfg_r       <= 32'h0000_0000;
      timer_cnt_r  <= TIMER_IDLE;
      timer_int_r  <= 1'b0;
      stable_cnt_r <= 64'h0000_0000_0000_0000;
    end else begin
      if (wr_tid_s) begin
        tid_r[CSR_TID_TID_MSB:CSR_TID_TID_LSB] <= tid_eff_s[CSR_TID_TID_MSB:CSR_TID_TID_LSB];
      end
      if (wr_tcfg_s) begin
        tcfg_r <= tcfg_eff_s;
      end
      timer_cnt_r <= cnt_nxt_s;
      // A same-cycle set outranks a TICLR clear
      if (ti_set_s) begin
        timer_int_r <= 1'b1;
      end else if (ti_clr_s) begin
        timer_int_r <= 1'b0;
      end
      stable_cnt_r <= stable_cnt_r + 64'h0000_0000_0000_0001;
    end
  end

  // Zero-latency read mux merged into the CSR file's read path
  always_comb begin
    hit_s    = 1'b0;
    rvalue_s = 32'h0000_0000;
    if (csr_re) begin
      case (csr_num)
        CSR_TID:   begin hit_s = 1'b1; rvalue_s = tid_r;        end
        CSR_TCFG:  begin hit_s = 1'b1; rvalue_s = tcfg_r;       end
        CSR_TVAL:  begin hit_s = 1'b1; rvalue_s = timer_cnt_r;  end
        CSR_TICLR: begin hit_s = 1'b1; rvalue_s = 32'h0000_0000; end
        default:   begin hit_s = 1'b0; rvalue_s = 32'h0000_0000; end
      endcase
    end else begin
      hit_s    = 1'b0;
      rvalue_s = 32'h0000_0000;
    end
  end

  csr_timer_unit_int_sync #(
    .WIDTH  (HW_INT_NUM + 1),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({ipi_int_in, hw_int_in}),
    .dout  ({ipi_int_sync, hw_int_sync})
  );

  assign csr_hit    = hit_s;
  assign csr_rvalue = rvalue_s;
  assign timer_int  = timer_int_r;
  assign stable_cnt = stable_cnt_r;
  assign tid        = tid_r;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Scoreboard bench for csr_timer_unit: the driver predicts each cycle's outputs
// from a rule-level model and queues them; a negedge monitor pops and compares.
module tb_csr_timer_unit;
  import csr_timer_unit_pkg::*;

  localparam logic [31:0] CORE_ID = 32'h0000_0003;
  localparam int HWN  = 8;
  localparam int SYNC = 2;

  logic                     clk;
  logic                     reset;
  logic                     csr_re;
  logic [CSR_NUM_WIDTH-1:0] csr_num;
  logic                     csr_we;
  logic [31:0]              csr_wmask;
  logic [31:0]              csr_wvalue;
  logic [31:0]              csr_rvalue;
  logic                     csr_hit;
  logic [HWN-1:0]           hw_int_in;
  logic                     ipi_int_in;
  logic                     timer_int;
  logic [HWN-1:0]           hw_int_sync;
  logic                     ipi_int_sync;
  logic [63:0]              stable_cnt;
  logic [31:0]              tid;

  csr_timer_unit #(.CORE_ID(CORE_ID), .HW_INT_NUM(HWN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .csr_hit(csr_hit), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .timer_int(timer_int), .hw_int_sync(hw_int_sync), .ipi_int_sync(ipi_int_sync),
    .stable_cnt(stable_cnt), .tid(tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           hit;
    logic [31:0]    rval;
    logic           ti;
    logic [HWN-1:0] hw;
    logic           ipi;
    logic [63:0]    sc;
    logic [31:0]    tid;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  // Reference state: register contents as the spec defines them
  logic [31:0]    m_tid, m_tcfg, m_cnt;
  logic           m_ti;
  logic [63:0]    m_sc;
  logic [HWN:0]   m_hist[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tid  = CORE_ID;
    m_tcfg = 32'h0000_0000;
    m_cnt  = 32'hFFFF_FFFF;
    m_ti   = 1'b0;
    m_sc   = 64'h0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] m, input logic [31:0] v);
    return (m & v) | (~m & o);
  endfunction

  // Called just after a rising edge: drive one cycle, queue the prediction, advance the model
  task automatic step(input logic re, input logic [13:0] num, input logic we,
                      input logic [31:0] wm, input logic [31:0] wv,
                      input logic [HWN-1:0] hw, input logic ipi);
    exp_t e;
    logic [31:0] eff_tcfg, ncnt;
    logic set;
    csr_re = re; csr_num = num; csr_we = we; csr_wmask = wm; csr_wvalue = wv;
    hw_int_in = hw; ipi_int_in = ipi;

    e.hit  = re && (num == 14'h0040 || num == 14'h0041 || num == 14'h0042 || num == 14'h0044);
    e.rval = 32'h0;
    if (e.hit) begin
      if (num == 14'h0040) e.rval = m_tid;
      else if (num == 14'h0041) e.rval = m_tcfg;
      else if (num == 14'h0042) e.rval = m_cnt;
      else e.rval = 32'h0;
    end
    e.ti  = m_ti;
    e.ipi = m_hist[0][HWN];
    e.hw  = m_hist[0][HWN-1:0];
    e.sc  = m_sc;
    e.tid = m_tid;
    sb_q.push_back(e);

    eff_tcfg = merge(m_tcfg, wm, wv);
    set  = 1'b0;
    ncnt = m_cnt;
    if (we && num == 14'h0041 && eff_tcfg[0]) ncnt = eff_tcfg & 32'hFFFF_FFFC;
    else if (m_tcfg[0] && m_cnt == 32'h0) begin
      set  = 1'b1;
      ncnt = m_tcfg[1] ? (m_tcfg & 32'hFFFF_FFFC) : 32'hFFFF_FFFF;
    end else if (m_tcfg[0] && m_cnt != 32'hFFFF_FFFF) ncnt = m_cnt - 32'h1;
    if (set) m_ti = 1'b1;
    else if (we && num == 14'h0044 && wm[0] && wv[0]) m_ti = 1'b0;
    m_cnt = ncnt;
    if (we && num == 14'h0041) m_tcfg = eff_tcfg;
    if (we && num == 14'h0040) m_tid = merge(m_tid, wm, wv);
    m_sc = m_sc + 64'h1;
    void'(m_hist.pop_front());
    m_hist.push_back({ipi, hw});

    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] num, input int n);
    for (int i = 0; i < n; i++) step(1'b1, num, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
    step(1'b1, 14'h0042, 1'b1, wm, wv, 8'h00, 1'b0);
    csr_num = num;
  endtask

  task automatic wrn(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
    step(1'b0, num, 1'b1, wm, wv, 8'h00, 1'b0);
  endtask

  // Monitor: compare every queued prediction against what the DUT presents
  always @(negedge clk) begin
    if (reset && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("csr_hit",      64'(csr_hit),      64'(mon_e.hit));
      chk("csr_rvalue",   64'(csr_rvalue),   64'(mon_e.rval));
      chk("timer_int",    64'(timer_int),    64'(mon_e.ti));
      chk("hw_int_sync",  64'(hw_int_sync),  64'(mon_e.hw));
      chk("ipi_int_sync", 64'(ipi_int_sync), 64'(mon_e.ipi));
      chk("stable_cnt",   stable_cnt,        mon_e.sc);
      chk("tid",          64'(tid),          64'(mon_e.tid));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] rn;
    logic [31:0] rw;
    logic [HWN-1:0] rhw;
    logic rip;
    reset = 1'b0; csr_re = 1'b0; csr_num = 14'h0; csr_we = 1'b0;
    csr_wmask = 32'h0; csr_wvalue = 32'h0; hw_int_in = 8'h00; ipi_int_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset values, stable counter start
    rd(14'h0040, 1);
    rd(14'h0042, 6);
    // One-shot InitVal=4
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0011);
    rd(14'h0042, 22);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    rd(14'h0042, 4);
    // Periodic InitVal=1
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0007);
    rd(14'h0042, 7);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    rd(14'h0042, 8);
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0000);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    // Periodic InitVal=0: set beats clear
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0003);
    rd(14'h0042, 2);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    rd(14'h0044, 2);
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0000);
    wrn(14'h0044, 32'hFFFF_FFFF, 32'h0000_0001);
    rd(14'h0041, 2);
    // Freeze via masked En clear, then re-enable
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0041);
    rd(14'h0042, 5);
    wrn(14'h0041, 32'h0000_0001, 32'h0000_0000);
    rd(14'h0042, 5);
    wrn(14'h0041, 32'h0000_0001, 32'h0000_0001);
    rd(14'h0042, 4);
    // TID masked write, TVAL write ignored
    wrn(14'h0040, 32'h0000_FFFF, 32'h1234_ABCD);
    wrn(14'h0042, 32'hFFFF_FFFF, 32'h0000_0000);
    rd(14'h0040, 2);
    // Synchronizer latency
    for (int i = 0; i < 4; i++) step(1'b0, 14'h0000, 1'b0, 32'h0, 32'h0, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 14'h0000, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);

    // Randomized traffic
    rhw = 8'h00; rip = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: rn = 14'h0040;
        1: rn = 14'h0041;
        2: rn = 14'h0042;
        3: rn = 14'h0043;
        4: rn = 14'h0044;
        default: rn = 14'($urandom);
      endcase
      rw = (rn == 14'h0041) ? ($urandom & 32'h0000_007F) : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rhw = 8'($urandom);
        rip = 1'($urandom);
      end
      step(1'($urandom), rn, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom, rw, rhw, rip);
    end

    // Asynchronous reset mid-count
    wrn(14'h0041, 32'hFFFF_FFFF, 32'h0000_0041);
    for (int i = 0; i < 6; i++) step(1'b0, 14'h0000, 1'b0, 32'h0, 32'h0, 8'hFF, 1'b1);
    csr_re = 1'b1; csr_num = 14'h0042; csr_we = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_timer_int",  64'(timer_int),    64'h0);
    chk("rst_stable_cnt", stable_cnt,        64'h0);
    chk("rst_tid",        64'(tid),          64'(CORE_ID));
    chk("rst_hw_sync",    64'(hw_int_sync),  64'h0);
    chk("rst_ipi_sync",   64'(ipi_int_sync), 64'h0);
    chk("rst_tval",       64'(csr_rvalue),   64'hFFFF_FFFF);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    rd(14'h0042, 3);
    rd(14'h0041, 2);

    @(negedge clk);
    #1;
    chk("sb_drain", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
